// File: rtl/cache_flush_seq_pkg.sv
// Shared definitions for the cache INVAL_ALL flush sequencer: way count,
// default array geometry and the sequencer state encoding.
package cache_flush_seq_pkg;

    localparam int WAYS          = 4;
    localparam int IDX_BITS_DEF  = 13;
    localparam int TAG_BITS_DEF  = 14;
    localparam int LINE_BITS_DEF = 256;
    localparam int CNT_BITS_DEF  = 16;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_RD   = 3'd1,
        FS_CHK  = 3'd2,
        FS_WB   = 3'd3,
        FS_CLR  = 3'd4,
        FS_DONE = 3'd5
    } fs_state_e;

endpackage

// File: rtl/cache_flush_seq_pick.sv
// Lowest-set-bit picker: selects the next way to write back from the
// pending mask, as a one-hot mask and as a 2-bit way number.
module cache_flush_pick
    import cache_flush_seq_pkg::*;
(
    input  logic [WAYS-1:0] mask_i,
    output logic [WAYS-1:0] onehot_o,
    output logic [1:0]      way_o
);

    always_comb begin
        // NOTE: outputs get defaults before the loop so every path assigns them; no latch.
        onehot_o = '0;
        way_o    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mask_i[w]) begin
                onehot_o    = '0;
                onehot_o[w] = 1'b1;
                way_o       = 2'(w);
            end
        end
    end

endmodule

// File: rtl/cache_flush_seq.sv
// INVAL_ALL sequencer: walks every set, writes back valid+dirty lines in
// flush mode, then clears valid/dirty/LRU of the set.
module cache_flush_seq
    import cache_flush_seq_pkg::*;
#(
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int TAG_BITS  = TAG_BITS_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         wb_mode,
    output logic                         busy,
    output logic                         done,
    output logic                         arr_rd,
    output logic [IDX_BITS-1:0]          arr_idx,
    input  logic [WAYS*TAG_BITS-1:0]     tag_in,
    input  logic [WAYS-1:0]              val_in,
    input  logic [WAYS-1:0]              dirty_in,
    input  logic [WAYS*LINE_BITS-1:0]    line_in,
    output logic                         clr_we,
    output logic                         mm_req,
    input  logic                         mm_ack,
    output logic [TAG_BITS+IDX_BITS-1:0] mm_addr,
    output logic [LINE_BITS-1:0]         mm_wd,
    output logic [CNT_BITS-1:0]          wb_count
);

    localparam logic [IDX_BITS-1:0] IDX_LAST = {IDX_BITS{1'b1}};

    fs_state_e                         state_q;
    logic                              wb_mode_q;
    logic [IDX_BITS-1:0]               arr_idx_q;
    logic [CNT_BITS-1:0]               wb_count_q;
    logic [WAYS-1:0]                   pend_q;
    logic [WAYS-1:0][TAG_BITS-1:0]     tags_q;
    logic                              busy_q, done_q, arr_rd_q, clr_we_q, mm_req_q;

    logic [WAYS-1:0]                   chk_pend;
    logic [WAYS-1:0]                   pend_d;
    logic [WAYS-1:0]                   pick_onehot;
    logic [1:0]                        pick_way;
    logic [WAYS-1:0][LINE_BITS-1:0]    line_w;

    cache_flush_pick u_pick (
        .mask_i   (pend_q),
        .onehot_o (pick_onehot),
        .way_o    (pick_way)
    );

    assign line_w   = line_in;
    assign chk_pend = val_in & dirty_in & {WAYS{wb_mode_q}};
    assign pend_d   = pend_q & ~pick_onehot;

    // Address and data follow the picked way, so they move to the next pending
    // way exactly one cycle after a transfer and stay put while stalled.
    assign mm_addr  = {tags_q[pick_way], arr_idx_q};
    assign mm_wd    = line_w[pick_way];

    assign busy     = busy_q;
    assign done     = done_q;
    assign arr_rd   = arr_rd_q;
    assign arr_idx  = arr_idx_q;
    assign clr_we   = clr_we_q;
    assign mm_req   = mm_req_q;
    assign wb_count = wb_count_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            wb_mode_q  <= 1'b0;
            arr_idx_q  <= '0;
            wb_count_q <= '0;
            pend_q     <= '0;
            tags_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            arr_rd_q   <= 1'b0;
            clr_we_q   <= 1'b0;
            mm_req_q   <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (start) begin
                        wb_mode_q  <= wb_mode;
                        arr_idx_q  <= '0;
                        wb_count_q <= '0;
                        busy_q     <= 1'b1;
                        arr_rd_q   <= 1'b1;
                        state_q    <= FS_RD;
                    end
                end
                FS_RD: begin
                    arr_rd_q <= 1'b0;
                    state_q  <= FS_CHK;
                end
                FS_CHK: begin
                    pend_q <= chk_pend;
                    tags_q <= tag_in;
                    if (|chk_pend) begin
                        mm_req_q <= 1'b1;
                        state_q  <= FS_WB;
                    end else begin
                        clr_we_q <= 1'b1;
                        state_q  <= FS_CLR;
                    end
                end
                FS_WB: begin
                    if (mm_req_q && mm_ack) begin
                        pend_q     <= pend_d;
                        wb_count_q <= wb_count_q + CNT_BITS'(1);
                        if (pend_d == '0) begin
                            mm_req_q <= 1'b0;
                            clr_we_q <= 1'b1;
                            state_q  <= FS_CLR;
                        end
                    end
                end
                FS_CLR: begin
                    clr_we_q <= 1'b0;
                    if (arr_idx_q == IDX_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FS_DONE;
                    end else begin
                        arr_idx_q <= arr_idx_q + IDX_BITS'(1);
                        arr_rd_q  <= 1'b1;
                        state_q   <= FS_RD;
                    end
                end
                FS_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= FS_IDLE;
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_flush_seq.sv
// Randomised bench for cache_flush_seq: a tag/valid/dirty/data array model,
// a ready-side memory port and a per-pass writeback list built from the array contents.
module tb_cache_flush_seq;
    import cache_flush_seq_pkg::*;

    localparam int IDX  = 2;
    localparam int TAG  = 14;
    localparam int LINE = 32;
    localparam int CNT  = 16;
    localparam int SETS = 1 << IDX;
    localparam int AW   = TAG + IDX;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 wb_mode = 1'b0;
    logic                 busy, done, arr_rd, clr_we, mm_req;
    logic [IDX-1:0]       arr_idx;
    logic [WAYS*TAG-1:0]  tag_in = '0;
    logic [WAYS-1:0]      val_in = '0;
    logic [WAYS-1:0]      dirty_in = '0;
    logic [WAYS*LINE-1:0] line_in = '0;
    logic                 mm_ack = 1'b0;
    logic [AW-1:0]        mm_addr;
    logic [LINE-1:0]      mm_wd;
    logic [CNT-1:0]       wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    cache_flush_seq #(
        .IDX_BITS (IDX), .TAG_BITS (TAG), .LINE_BITS (LINE), .CNT_BITS (CNT)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .wb_mode (wb_mode),
        .busy (busy), .done (done), .arr_rd (arr_rd), .arr_idx (arr_idx),
        .tag_in (tag_in), .val_in (val_in), .dirty_in (dirty_in), .line_in (line_in),
        .clr_we (clr_we), .mm_req (mm_req), .mm_ack (mm_ack),
        .mm_addr (mm_addr), .mm_wd (mm_wd), .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    // Cache array contents; a set counts as cleared when its clear generation matches cur_gen.
    logic [TAG-1:0]  mem_tag   [SETS][WAYS];
    logic [LINE-1:0] mem_data  [SETS][WAYS];
    logic            mem_val   [SETS][WAYS];
    logic            mem_dirty [SETS][WAYS];
    int              cur_gen = 1;
    int              clr_gen [SETS];

    always @(posedge clk) begin
        if (arr_rd) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_in[w*TAG +: TAG]    <= mem_tag[arr_idx][w];
                line_in[w*LINE +: LINE] <= mem_data[arr_idx][w];
                val_in[w]   <= mem_val[arr_idx][w] && (clr_gen[arr_idx] != cur_gen);
                dirty_in[w] <= mem_dirty[arr_idx][w] && (clr_gen[arr_idx] != cur_gen);
            end
        end
        if (clr_we) clr_gen[arr_idx] <= cur_gen;
    end

    // Memory ready side: stall each beat stall_cfg cycles, then accept with ack_pct chance.
    int ack_pct = 100;
    int stall_cfg = 0;
    int hold = 0;
    always begin
        @(posedge clk);
        #1;
        if (mm_req && hold < stall_cfg) begin
            mm_ack = 1'b0;
            hold++;
        end else begin
            mm_ack = ($urandom_range(99) < ack_pct);
            if (mm_req && mm_ack) hold = 0;
        end
    end

    // Passive monitor: cumulative counters only; tests work with deltas.
    int              mon_done = 0, mon_req = 0, mon_stab = 0, mon_ovl = 0;
    int              mon_clr [SETS];
    logic [AW-1:0]   xf_addr [$];
    logic [LINE-1:0] xf_data [$];
    logic            hold_prev = 1'b0;
    logic [AW-1:0]   prev_addr;
    logic [LINE-1:0] prev_wd;
    always @(negedge clk) begin
        if (done) mon_done++;
        if (arr_rd && clr_we) mon_ovl++;
        if (clr_we) mon_clr[arr_idx]++;
        if (mm_req) mon_req++;
        if (hold_prev && !rst && (!mm_req || mm_addr !== prev_addr || mm_wd !== prev_wd)) mon_stab++;
        if (mm_req && mm_ack) begin
            xf_addr.push_back(mm_addr);
            xf_data.push_back(mm_wd);
        end
        hold_prev = mm_req && !mm_ack;
        prev_addr = mm_addr;
        prev_wd   = mm_wd;
    end

    function automatic bit live(int s, int w);
        return mem_val[s][w] && mem_dirty[s][w] && (clr_gen[s] != cur_gen);
    endfunction

    task automatic fill_clear();
        cur_gen++;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mem_val[s][w]   = 1'b0;
                mem_dirty[s][w] = 1'b0;
                mem_tag[s][w]   = TAG'($urandom);
                mem_data[s][w]  = LINE'($urandom);
            end
    endtask

    task automatic fill_random();
        cur_gen++;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mem_val[s][w]   = 1'($urandom);
                mem_dirty[s][w] = 1'($urandom);
                mem_tag[s][w]   = TAG'($urandom);
                mem_data[s][w]  = LINE'($urandom);
            end
    endtask

    // One complete pass; expected writebacks are every live line in set/way order when flushing.
    task automatic run_op(input logic mode, input int inj, input string nm);
        logic [AW-1:0]   ea [$];
        logic [LINE-1:0] ed [$];
        int nexp, cyc, busy_bad, x0, d0, s0, o0, exp_cyc;
        int c0 [SETS];
        bit seen;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (mode && live(s, w)) begin
                    ea.push_back({mem_tag[s][w], IDX'(s)});
                    ed.push_back(mem_data[s][w]);
                end
        nexp = ea.size();
        x0 = xf_addr.size(); d0 = mon_done; s0 = mon_stab; o0 = mon_ovl;
        for (int s = 0; s < SETS; s++) c0[s] = mon_clr[s];

        @(negedge clk);
        start = 1'b1;
        wb_mode = mode;
        cyc = 0; seen = 0; busy_bad = 0;
        while (!seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inj);
            wb_mode = ~mode;
            if (done) seen = 1;
            else if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;

        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL %s done_timeout: got no done after %0d cycles", nm, cyc); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b want 0", nm, busy); end
        if (ack_pct == 100) begin
            exp_cyc = 3 * SETS + 1 + nexp * (1 + stall_cfg);
            n_checks++;
            if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", nm, cyc, exp_cyc); end
        end
        n_checks++;
        if (wb_count !== CNT'(nexp)) begin n_fail++; $display("FAIL %s wb_count: got %0d want %0d", nm, wb_count, nexp); end
        n_checks++;
        if (xf_addr.size() - x0 != nexp) begin
            n_fail++; $display("FAIL %s xfer_count: got %0d want %0d", nm, xf_addr.size() - x0, nexp);
        end
        for (int i = 0; i < nexp && x0 + i < xf_addr.size(); i++) begin
            n_checks++;
            if (xf_addr[x0+i] !== ea[i] || xf_data[x0+i] !== ed[i]) begin
                n_fail++;
                $display("FAIL %s xfer%0d: got addr %h data %h want addr %h data %h",
                         nm, i, xf_addr[x0+i], xf_data[x0+i], ea[i], ed[i]);
            end
        end
        for (int s = 0; s < SETS; s++) begin
            n_checks++;
            if (mon_clr[s] - c0[s] != 1) begin
                n_fail++; $display("FAIL %s clr_set%0d: got %0d pulses want 1", nm, s, mon_clr[s] - c0[s]);
            end
        end
        n_checks++;
        if (busy_bad != 0) begin n_fail++; $display("FAIL %s busy_low_early: got %0d cycles want 0", nm, busy_bad); end
        n_checks++;
        if (mon_ovl != o0) begin n_fail++; $display("FAIL %s rd_clr_overlap: got %0d want 0", nm, mon_ovl - o0); end
        n_checks++;
        if (mon_stab != s0) begin n_fail++; $display("FAIL %s stall_stability: got %0d changes want 0", nm, mon_stab - s0); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (mon_done - d0 != 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", nm, mon_done - d0); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, arr_rd, clr_we, mm_req} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, arr_rd, clr_we, mm_req});
        end
        n_checks++;
        if (arr_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", arr_idx); end
        n_checks++;
        if (wb_count !== '0) begin n_fail++; $display("FAIL reset_wb_count: got %0d want 0", wb_count); end
        n_checks++;
        if (mm_addr !== '0) begin n_fail++; $display("FAIL reset_mm_addr: got %h want 0", mm_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_invalid();
        fill_clear();
        ack_pct = 100; stall_cfg = 0;
        run_op(1'b1, 0, "all_invalid");
    endtask

    task automatic test_two_ways();
        for (int m = 1; m >= 0; m--) begin
            fill_clear();
            mem_val[1][0] = 1'b1; mem_dirty[1][0] = 1'b1; mem_tag[1][0] = 14'h0AB;
            mem_val[1][2] = 1'b1; mem_dirty[1][2] = 1'b1; mem_tag[1][2] = 14'h1CD;
            ack_pct = 100; stall_cfg = 0;
            run_op(1'(m), 0, m == 1 ? "two_ways_flush" : "two_ways_inval");
        end
    endtask

    task automatic test_stall();
        int r0;
        fill_clear();
        mem_val[3][3] = 1'b1; mem_dirty[3][3] = 1'b1;
        ack_pct = 100; stall_cfg = 5;
        r0 = mon_req;
        run_op(1'b1, 0, "stall");
        n_checks++;
        if (mon_req - r0 != 6) begin n_fail++; $display("FAIL stall_req_cycles: got %0d want 6", mon_req - r0); end
        stall_cfg = 0;
    endtask

    task automatic test_back_to_back();
        fill_clear();
        mem_dirty[0][1] = 1'b1;
        mem_val[2][1] = 1'b1; mem_dirty[2][1] = 1'b1;
        ack_pct = 100; stall_cfg = 0;
        run_op(1'b1, 5, "invalid_dirty_busy_start");
    endtask

    task automatic test_reset_mid_wb();
        int cnt;
        fill_clear();
        mem_val[2][1] = 1'b1; mem_dirty[2][1] = 1'b1;
        ack_pct = 0; stall_cfg = 0;
        @(negedge clk);
        start = 1'b1; wb_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!mm_req && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (!mm_req) begin n_fail++; $display("FAIL rst_wb_reach: got mm_req %b want 1", mm_req); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, arr_rd, clr_we, mm_req} !== 5'b0) begin
            n_fail++; $display("FAIL rst_wb_ctrl: got %b want 00000", {busy, done, arr_rd, clr_we, mm_req});
        end
        n_checks++;
        if (wb_count !== '0 || arr_idx !== '0) begin
            n_fail++; $display("FAIL rst_wb_regs: got cnt %0d idx %0d want 0 0", wb_count, arr_idx);
        end
        rst = 1'b0;
        ack_pct = 100;
        @(negedge clk);
        run_op(1'b1, 0, "after_rst");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            fill_random();
            ack_pct = (it % 3 == 0) ? 100 : int'($urandom_range(90, 30));
            stall_cfg = 0;
            run_op(1'($urandom), (it % 2) ? int'($urandom_range(12, 2)) : 0, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_invalid();
        test_two_ways();
        test_stall();
        test_back_to_back();
        test_reset_mid_wb();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
